pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic buffer that sits between two pipeline stages of the RISC-V core, for example between decode and execute. It replaces the fixed stage registers with a WIDTH-bit, DEPTH-entry FIFO. Transfers use valid/ready handshakes on both sides. The block adds a synchronous flush for branch and jump redirects, inserts a NOP bubble when it is empty, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- WIDTH, 64, bit width of one packed stage bus (any ≥1; stage buses are packed structs cast to logic vectors).
- DEPTH, 2, number of entries. Must be a power of two and ≥2. Elaboration fails otherwise.
- NOP_VALUE, '0, value driven on out_data when the buffer is empty. '0 decodes as op_type NOP with rf_wr_en=0.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all contents this cycle.
- in_valid  in  1  upstream has a beat on in_data.
- in_data  in  WIDTH  upstream beat.
- in_ready  out  1  buffer can accept a beat.
- out_valid  out  1  out_data holds a real beat.
- out_data  out  WIDTH  oldest entry, or NOP_VALUE when empty.
- out_ready  in  1  downstream consumes the beat.
- count  out  $clog2(DEPTH+1)  current occupancy.
- stall_cnt  out  CNT_W  saturating count of stalled output cycles.

## Operation
- Storage: DEPTH×WIDTH array, write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits. Pointers wrap naturally. Occupancy is held in count.
- Entry contents are not reset. Only the pointers, count and stall_cnt are reset.
- Push: occurs when in_valid && in_ready && !flush. The beat is written at wr_ptr, then wr_ptr increments.
- Pop: occurs when out_valid && out_ready && !flush. rd_ptr then increments.
- in_ready = (count != DEPTH). It is a function of registered state only. There is no combinational path from out_ready or flush to in_ready.
- When full, a same-cycle pop does not open a push slot. in_ready stays 0 for that cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid=1, else NOP_VALUE. Downstream may therefore consume out_data unconditionally as a bubble.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together (only possible when 0<count<DEPTH): unchanged.
  - neither: unchanged.
- Flush has highest priority. Next state is count=0, wr_ptr=0, rd_ptr=0.
  - Any push in the flush cycle is dropped, even if in_valid && in_ready.
  - Any pop in the flush cycle is not recorded by the buffer. Downstream must also treat its flush-cycle beat as killed.
- stall_cnt increments by 1 each cycle with out_valid && !out_ready && !flush. It holds at 2^CNT_W−1. Flush does not clear it; only rst does.
- Reset mid-operation clears everything immediately (asynchronous assertion). Deassertion must be synchronised externally to clk.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=NOP_VALUE, count=0, stall_cnt=0.
- Latency: a beat pushed at edge N appears on out_valid/out_data after edge N. There is no same-cycle bypass from in_data to out_data.
- Throughput: one beat per cycle sustained for DEPTH≥2 with out_ready held high. count toggles between 0 and 1, or holds at 1 under continuous push and pop.
- Flush at edge N: out_valid=0 and in_ready=1 from edge N onward. The first post-flush push can be accepted in the cycle immediately after edge N.
- out_data is a mux on registered state. It is stable for the whole cycle while out_valid=1 and out_ready=0.

## Test plan
- Reset and bubble: assert rst with WIDTH=64 and NOP_VALUE='0 → out_valid=0, out_data=0, in_ready=1, count=0, stall_cnt=0.
- Streaming: push 0x1, 0x2, 0x3 on consecutive cycles with out_ready=1 → each beat appears one cycle after its push, in order. count never exceeds 1 and stall_cnt stays 0.
- Fill and back-pressure: DEPTH=4, out_ready=0, push 0xA..0xD → count=4 and in_ready=0. A fifth beat 0xE is held upstream. Raise out_ready → outputs 0xA,0xB,0xC,0xD,0xE, with 0xE accepted only after the first pop frees a slot.
- Wrap-around: DEPTH=2, run 10 beats with alternating stall patterns → output order matches input order and the pointers wrap without loss.
- Flush with simultaneous push: count=2, and in one cycle flush=1, in_valid=1, out_ready=1 → next cycle count=0, out_valid=0, out_data=NOP_VALUE. The pushed beat never appears.
- Stall counter saturation: CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15 and it holds. A flush leaves it at 15; rst clears it to 0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf
//   Elastic buffer between two pipeline stages (for example decode -> execute).
//   It is a DEPTH-entry, WIDTH-bit FIFO with valid/ready handshakes on both sides.
//   It also provides:
//     - a synchronous flush for branch and jump redirects,
//     - a NOP bubble on out_data whenever the buffer is empty,
//     - a saturating stall-cycle counter.
//
// Parameters
//   WIDTH     : bits per stage beat
//   DEPTH     : number of entries; must be a power of two and >= 2
//   NOP_VALUE : value driven on out_data when the buffer is empty
//   CNT_W     : width of the stall counter
//
// Ports
//   clk, rst             : clock and asynchronous active-high reset
//   flush                : discards all contents at the next edge
//   in_valid/in_data     : upstream beat
//   in_ready             : buffer can accept a beat (registered state only)
//   out_valid/out_data   : oldest entry, or NOP_VALUE when empty
//   out_ready            : downstream consumes the beat
//   count                : current occupancy
//   stall_cnt            : saturating count of cycles with out_valid && !out_ready
module pipe_stage_buf #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("pipe_stage_buf: DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Both handshake flags come from count alone. When the buffer is full, a
  // pop in the same cycle therefore cannot open a push slot.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : NOP_VALUE;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately left unreset; out_data is masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Flush does not clear the stall counter. It is a perf monitor that only
  // reset clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned STALL_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] count;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_buf #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .NOP_VALUE('0),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: accepted beats are queued in order; the head is the expected output.
  logic [WIDTH-1:0] sb_q[$];
  int unsigned      m_stall;
  bit               last_push;
  int               n_checks;
  int               n_pass;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  task automatic check_outputs(input string phase);
    int unsigned occ;
    logic [63:0] exp_data;
    occ = sb_q.size();
    exp_data = (occ != 0) ? sb_q[0] : 64'h0;
    check({phase, ".out_valid"}, 64'(out_valid), 64'(occ != 0));
    check({phase, ".out_data"},  out_data,       exp_data);
    check({phase, ".in_ready"},  64'(in_ready),  64'(occ != DEPTH));
    check({phase, ".count"},     64'(count),     64'(occ));
    check({phase, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
  endtask

  // Check outputs mid-cycle, advance the model with the current inputs, then
  // cross the edge. Inputs are changed by the caller 1 time unit after the edge.
  task automatic step(input string phase);
    bit m_in_ready;
    bit m_out_valid;
    bit do_push;
    bit do_pop;
    @(negedge clk);
    check_outputs(phase);
    m_in_ready  = (sb_q.size() != DEPTH);
    m_out_valid = (sb_q.size() != 0);
    do_push = in_valid && m_in_ready && !flush;
    do_pop  = m_out_valid && out_ready && !flush;
    if (m_out_valid && !out_ready && !flush && m_stall != STALL_MAX) m_stall++;
    if (flush) begin
      sb_q.delete();
    end else begin
      if (do_pop) void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(in_data);
    end
    last_push = do_push;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string phase);
    rst = 1'b1;
    #1;
    sb_q.delete();
    m_stall = 0;
    check_outputs(phase);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int unsigned sent;
    n_checks = 0;
    n_pass   = 0;
    m_stall  = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b0;

    // Reset and bubble
    apply_reset("reset");
    step("idle");

    // Streaming with out_ready held high
    out_ready = 1'b1;
    for (int unsigned i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      step("stream");
    end
    in_valid = 1'b0;
    step("stream_tail");
    step("stream_tail");

    // Fill and back-pressure; 0xE is held upstream until a slot frees
    out_ready = 1'b0;
    for (int unsigned v = 'hA; v <= 'hD; v++) begin
      in_valid = 1'b1;
      in_data  = 64'(v);
      step("fill");
    end
    in_data = 64'hE;
    step("full_hold");
    check("full_hold.accepted", 64'(last_push), 64'(0));
    out_ready = 1'b1;
    last_push = 1'b0;
    for (int c = 0; c < 10 && !last_push; c++) step("drain_e");
    check("e_accepted_in_bound", 64'(last_push), 64'(1));
    in_valid = 1'b0;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) step("drain");
    step("drain_empty");

    // Wrap-around with alternating stall patterns on both sides
    sent = 0;
    for (int c = 0; c < 100 && sent < 10; c++) begin
      in_valid  = (c % 4 != 3);
      in_data   = 64'h100 + 64'(sent);
      out_ready = (c % 3 != 1);
      step("wrap");
      if (last_push) sent++;
    end
    check("wrap_sent_in_bound", 64'(sent), 64'(10));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) step("wrap_drain");
    step("wrap_empty");

    // Flush with a simultaneous push and pop
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h200 + 64'(i);
      step("pre_flush");
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hDEAD;
    out_ready = 1'b1;
    step("flush_cycle");
    flush    = 1'b0;
    in_valid = 1'b0;
    step("post_flush");
    check("post_flush.count", 64'(count), 64'(0));
    step("post_flush2");

    // Reset asserted with data in the buffer
    in_valid = 1'b1;
    in_data  = 64'h300;
    step("pre_rst");
    in_valid = 1'b0;
    apply_reset("mid_rst");
    step("after_mid_rst");

    // Stall counter saturation; flush keeps it, reset clears it
    in_valid = 1'b1;
    in_data  = 64'h55;
    out_ready = 1'b0;
    step("stall_load");
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) step("stall");
    check("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
    flush = 1'b1;
    step("stall_flush");
    flush = 1'b0;
    step("stall_after_flush");
    check("stall_kept", 64'(stall_cnt), 64'(STALL_MAX));
    apply_reset("stall_rst");
    check("stall_cleared", 64'(stall_cnt), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
